// File: rtl/vid_timing_gen_if.sv
// Pixel FIFO read port between the video FIFO and vid_timing_gen.
//   fifo_rdata     : head entry {R,G,B}, valid while fifo_empty=0
//   fifo_empty     : FIFO holds no entries
//   fifo_threshold : FIFO at or above half full
//   fifo_rd        : pop request, one clk per consumed pixel
// master = FIFO side, slave = timing generator side.
interface vid_timing_gen_if;
   logic [23:0] fifo_rdata;
   logic        fifo_empty;
   logic        fifo_threshold;
   logic        fifo_rd;

   modport master (output fifo_rdata, fifo_empty, fifo_threshold, input fifo_rd);
   modport slave  (input fifo_rdata, fifo_empty, fifo_threshold, output fifo_rd);
endinterface

// File: rtl/vid_timing_gen.sv
// vid_timing_gen: pixel/timing back end of the video controller.
// Divides clk into pixel strobes, runs h/v counters, decodes sync/blank,
// pops one FIFO entry per active pixel and registers RGB to the display.
// Timing fields are shadowed at enable and at each frame wrap.
//
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   en                  : controller enable
//   testpat             : colour-bar select (only with VID_TESTPAT_EN)
//   pcnt                : pixel divider, strobe every pcnt+1 clks
//   hend/hsize/hsync_start/hsync_end : horizontal timing fields
//   vend/vsize/vsync_start/vsync_end : vertical timing fields
//   fifo                : pixel FIFO read port (slave modport)
//   hsync/hblank/vsync/vblank, R/G/B, frame_start, underflow : outputs
//
// Optional build macro VID_TESTPAT_EN adds the testpat input and an
// internal 8-bar colour pattern source.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | disabled, outputs 0, waits for en and latches timing fields
// PREFILL | waiting for FIFO threshold before starting the raster
// RUN     | raster running, strobes/counters/outputs active
module vid_timing_gen #(
   parameter int CW = 13,
   parameter int PW = 6
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          en,
`ifdef VID_TESTPAT_EN
   input  logic          testpat,
`endif
   input  logic [PW-1:0] pcnt,
   input  logic [CW-1:0] hend,
   input  logic [CW-1:0] hsize,
   input  logic [CW-1:0] hsync_start,
   input  logic [CW-1:0] hsync_end,
   input  logic [CW-1:0] vend,
   input  logic [CW-1:0] vsize,
   input  logic [CW-1:0] vsync_start,
   input  logic [CW-1:0] vsync_end,
   vid_timing_gen_if.slave fifo,
   output logic          hsync,
   output logic          hblank,
   output logic          vsync,
   output logic          vblank,
   output logic [7:0]    R,
   output logic [7:0]    G,
   output logic [7:0]    B,
   output logic          frame_start,
   output logic          underflow
);

   typedef enum logic [1:0] {ST_IDLE, ST_PREFILL, ST_RUN} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] div_q, div_d, pcnt_s_q, pcnt_s_d;
   logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic [CW-1:0] hend_s_q, hend_s_d, hsize_s_q, hsize_s_d;
   logic [CW-1:0] hss_s_q, hss_s_d, hse_s_q, hse_s_d;
   logic [CW-1:0] vend_s_q, vend_s_d, vsize_s_q, vsize_s_d;
   logic [CW-1:0] vss_s_q, vss_s_d, vse_s_q, vse_s_d;
   logic          hsync_q, hsync_d, hblank_q, hblank_d;
   logic          vsync_q, vsync_d, vblank_q, vblank_d;
   logic [23:0]   rgb_q, rgb_d;
   logic          frame_start_q, frame_start_d, underflow_q, underflow_d;

   logic          load_cfg, clear_out;
   logic [CW-1:0] hend_m, vend_m;
   logic          strobe, h_out, v_out, active, h_last, v_last;
   logic          tp_on;
   logic [23:0]   tp_rgb;

   // A zero-length line or frame behaves as length 1.
   assign hend_m = (hend_s_q == '0) ? CW'(1) : hend_s_q;
   assign vend_m = (vend_s_q == '0) ? CW'(1) : vend_s_q;

   assign strobe = (state_q == ST_RUN) && (div_q == pcnt_s_q);
   assign h_out  = hcnt_q >= hsize_s_q;
   assign v_out  = vcnt_q >= vsize_s_q;
   assign active = strobe & ~h_out & ~v_out;
   assign h_last = hcnt_q >= (hend_m - CW'(1));
   assign v_last = vcnt_q >= (vend_m - CW'(1));

`ifdef VID_TESTPAT_EN
   logic [CW-1:0] hsize_div;
   logic [2:0]    bar;
   assign tp_on     = testpat;
   assign hsize_div = (hsize_s_q == '0) ? CW'(1) : hsize_s_q;
   // Only evaluated for active pixels (hcnt < hsize), so the index stays below 8.
   assign bar       = 3'({hcnt_q, 3'b000} / {3'b000, hsize_div});
   assign tp_rgb    = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
`else
   assign tp_on  = 1'b0;
   assign tp_rgb = '0;
`endif

   // Pops are gated by en so a disable mid-line releases the FIFO immediately.
   assign fifo.fifo_rd = active & en & ~fifo.fifo_empty & ~tp_on;

   always_comb begin
      state_d       = state_q;
      div_d         = div_q;
      hcnt_d        = hcnt_q;
      vcnt_d        = vcnt_q;
      pcnt_s_d      = pcnt_s_q;
      hend_s_d      = hend_s_q;
      hsize_s_d     = hsize_s_q;
      hss_s_d       = hss_s_q;
      hse_s_d       = hse_s_q;
      vend_s_d      = vend_s_q;
      vsize_s_d     = vsize_s_q;
      vss_s_d       = vss_s_q;
      vse_s_d       = vse_s_q;
      hsync_d       = hsync_q;
      hblank_d      = hblank_q;
      vsync_d       = vsync_q;
      vblank_d      = vblank_q;
      rgb_d         = rgb_q;
      frame_start_d = 1'b0;
      underflow_d   = underflow_q;
      load_cfg      = 1'b0;
      clear_out     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            clear_out = 1'b1;
            if (en) begin
               load_cfg = 1'b1;
               div_d    = '0;
               hcnt_d   = '0;
               vcnt_d   = '0;
               // The test pattern needs no FIFO data, so skip the prefill wait.
               state_d  = tp_on ? ST_RUN : ST_PREFILL;
            end
         end
         ST_PREFILL: begin
            clear_out = 1'b1;
            if (!en) begin
               state_d = ST_IDLE;
            end else if (fifo.fifo_threshold) begin
               state_d = ST_RUN;
               div_d   = '0;
               hcnt_d  = '0;
               vcnt_d  = '0;
            end
         end
         ST_RUN: begin
            if (!en) begin
               state_d   = ST_IDLE;
               clear_out = 1'b1;
            end else if (strobe) begin
               div_d         = '0;
               hblank_d      = h_out;
               vblank_d      = v_out;
               hsync_d       = (hcnt_q >= hss_s_q) && (hcnt_q < hse_s_q);
               vsync_d       = (vcnt_q >= vss_s_q) && (vcnt_q < vse_s_q);
               frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
               if (!active) begin
                  rgb_d = '0;
               end else if (tp_on) begin
                  rgb_d = tp_rgb;
               end else if (fifo.fifo_empty) begin
                  rgb_d       = '0;
                  underflow_d = 1'b1;
               end else begin
                  rgb_d = fifo.fifo_rdata;
               end
               if (h_last) begin
                  hcnt_d = '0;
                  if (v_last) begin
                     vcnt_d   = '0;
                     load_cfg = 1'b1;
                  end else begin
                     vcnt_d = vcnt_q + CW'(1);
                  end
               end else begin
                  hcnt_d = hcnt_q + CW'(1);
               end
            end else begin
               div_d = div_q + PW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load_cfg) begin
         pcnt_s_d  = pcnt;
         hend_s_d  = hend;
         hsize_s_d = hsize;
         hss_s_d   = hsync_start;
         hse_s_d   = hsync_end;
         vend_s_d  = vend;
         vsize_s_d = vsize;
         vss_s_d   = vsync_start;
         vse_s_d   = vsync_end;
      end

      if (clear_out) begin
         hsync_d       = 1'b0;
         hblank_d      = 1'b0;
         vsync_d       = 1'b0;
         vblank_d      = 1'b0;
         rgb_d         = '0;
         frame_start_d = 1'b0;
         underflow_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         div_q         <= '0;
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         pcnt_s_q      <= '0;
         hend_s_q      <= '0;
         hsize_s_q     <= '0;
         hss_s_q       <= '0;
         hse_s_q       <= '0;
         vend_s_q      <= '0;
         vsize_s_q     <= '0;
         vss_s_q       <= '0;
         vse_s_q       <= '0;
         hsync_q       <= 1'b0;
         hblank_q      <= 1'b0;
         vsync_q       <= 1'b0;
         vblank_q      <= 1'b0;
         rgb_q         <= '0;
         frame_start_q <= 1'b0;
         underflow_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         div_q         <= div_d;
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         pcnt_s_q      <= pcnt_s_d;
         hend_s_q      <= hend_s_d;
         hsize_s_q     <= hsize_s_d;
         hss_s_q       <= hss_s_d;
         hse_s_q       <= hse_s_d;
         vend_s_q      <= vend_s_d;
         vsize_s_q     <= vsize_s_d;
         vss_s_q       <= vss_s_d;
         vse_s_q       <= vse_s_d;
         hsync_q       <= hsync_d;
         hblank_q      <= hblank_d;
         vsync_q       <= vsync_d;
         vblank_q      <= vblank_d;
         rgb_q         <= rgb_d;
         frame_start_q <= frame_start_d;
         underflow_q   <= underflow_d;
      end
   end

   assign hsync       = hsync_q;
   assign hblank      = hblank_q;
   assign vsync       = vsync_q;
   assign vblank      = vblank_q;
   assign R           = rgb_q[23:16];
   assign G           = rgb_q[15:8];
   assign B           = rgb_q[7:0];
   assign frame_start = frame_start_q;
   assign underflow   = underflow_q;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Bench for vid_timing_gen: per-cycle reference model of the raster
// (pixel index arithmetic), a table of frame-level metrics, hand
// sequences for the multi-cycle corners, and randomized runs.
module tb_vid_timing_gen;
   localparam int CW = 13;
   localparam int PW = 6;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          en = 1'b0;
   logic [PW-1:0] pcnt = '0;
   logic [CW-1:0] hend = '0, hsize = '0, hss = '0, hse = '0;
   logic [CW-1:0] vend = '0, vsize = '0, vss = '0, vse = '0;
   logic          hsync, hblank, vsync, vblank, frame_start, underflow;
   logic [7:0]    R, G, B;

   vid_timing_gen_if fif();

   vid_timing_gen #(.CW(CW), .PW(PW)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .en(en),
`ifdef VID_TESTPAT_EN
      .testpat(1'b0),
`endif
      .pcnt(pcnt),
      .hend(hend),
      .hsize(hsize),
      .hsync_start(hss),
      .hsync_end(hse),
      .vend(vend),
      .vsize(vsize),
      .vsync_start(vss),
      .vsync_end(vse),
      .fifo(fif),
      .hsync(hsync),
      .hblank(hblank),
      .vsync(vsync),
      .vblank(vblank),
      .R(R),
      .G(G),
      .B(B),
      .frame_start(frame_start),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   int mst = 0;   // 0 idle, 1 prefill, 2 run
   int s_p, s_h, s_hs, s_hss, s_hse, s_v, s_vs, s_vss, s_vse;
   int k = 0;     // clocks since start of current frame
   bit e_hs, e_hb, e_vs, e_vb, e_fs, e_uf;
   logic [23:0] e_rgb;

   logic [23:0] q[$];
   bit refill = 1'b0;
   bit rnd_push = 1'b0;

   bit obs_fs, obs_rd, obs_hs, obs_vs;
   bit m_stb;
   int m_h, m_v;

   typedef struct {
      int p, h, hs, hss, hse, v, vs, vss, vse;
      int clks, rds, hs_cyc, vs_cyc;
   } vec_t;
   vec_t tbl[4];

   task automatic check(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   function automatic void zero_exp();
      e_hs = 0; e_hb = 0; e_vs = 0; e_vb = 0; e_fs = 0; e_uf = 0; e_rgb = '0;
   endfunction

   function automatic void load_shadow();
      s_p = int'(pcnt); s_h = int'(hend); s_hs = int'(hsize);
      s_hss = int'(hss); s_hse = int'(hse); s_v = int'(vend);
      s_vs = int'(vsize); s_vss = int'(vss); s_vse = int'(vse);
   endfunction

   task automatic drive_fifo();
      fif.fifo_empty = (q.size() == 0);
      fif.fifo_rdata = (q.size() != 0) ? q[0] : 24'hDEAD5A;
   endtask

   // One clock: compare at negedge, advance model, step past posedge.
   task automatic cycle();
      int pix, h, v, hm, vm;
      bit stb, act, erd;
      logic [30:0] want, got;
      drive_fifo();
      @(negedge clk);
      hm = (s_h == 0) ? 1 : s_h;
      vm = (s_v == 0) ? 1 : s_v;
      stb = 0; act = 0; pix = 0; h = 0; v = 0;
      if (mst == 2) begin
         pix = k / (s_p + 1);
         stb = (k % (s_p + 1)) == s_p;
         h   = pix % hm;
         v   = pix / hm;
         act = stb && (h < s_hs) && (v < s_vs);
      end
      erd  = (mst == 2) && en && act && !fif.fifo_empty;
      want = {erd, e_hs, e_hb, e_vs, e_vb, e_rgb, e_fs, e_uf};
      got  = {fif.fifo_rd, hsync, hblank, vsync, vblank, R, G, B, frame_start, underflow};
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL cycle t=%0t {rd,hs,hb,vs,vb,rgb,fs,uf}: got %h expected %h", $time, got, want);
      end
      obs_fs = frame_start; obs_rd = fif.fifo_rd; obs_hs = hsync; obs_vs = vsync;
      m_stb = stb; m_h = h; m_v = v;

      if (!reset_n) begin
         mst = 0; k = 0; zero_exp();
      end else begin
         case (mst)
            0: begin
               zero_exp();
               if (en) begin load_shadow(); mst = 1; end
            end
            1: begin
               zero_exp();
               if (!en) mst = 0;
               else if (fif.fifo_threshold) begin mst = 2; k = 0; end
            end
            default: begin
               if (!en) begin
                  mst = 0; zero_exp();
               end else begin
                  e_fs = 0;
                  if (stb) begin
                     e_hb = h >= s_hs;
                     e_hs = (h >= s_hss) && (h < s_hse);
                     e_vb = v >= s_vs;
                     e_vs = (v >= s_vss) && (v < s_vse);
                     e_fs = (pix == 0);
                     if (!act) e_rgb = '0;
                     else if (fif.fifo_empty) begin e_rgb = '0; e_uf = 1; end
                     else e_rgb = fif.fifo_rdata;
                     if (pix == hm * vm - 1) begin load_shadow(); k = 0; end
                     else k++;
                  end else begin
                     k++;
                  end
               end
            end
         endcase
      end

      @(posedge clk);
      if (erd) void'(q.pop_front());
      if (refill) begin
         while (q.size() < 4) q.push_back(24'($urandom));
      end else if (rnd_push && q.size() < 16 && ($urandom % 2 == 0)) begin
         q.push_back(24'($urandom));
      end
      #1;
   endtask

   task automatic set_cfg(input vec_t c);
      pcnt = PW'(c.p); hend = CW'(c.h); hsize = CW'(c.hs); hss = CW'(c.hss); hse = CW'(c.hse);
      vend = CW'(c.v); vsize = CW'(c.vs); vss = CW'(c.vss); vse = CW'(c.vse);
   endtask

   task automatic do_reset();
      reset_n = 0; en = 0;
      repeat (2) cycle();
      reset_n = 1;
   endtask

   // Advance until a frame_start is observed; returns cycles taken.
   task automatic wait_fs(input string name, output int n);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!obs_fs && n < 2000);
      if (!obs_fs) check({name, "_timeout"}, 0, 1);
   endtask

   // Metrics over one frame window starting at the currently observed frame_start.
   task automatic measure(output int clks, output int rds, output int hsc, output int vsc);
      clks = 1; rds = obs_rd; hsc = obs_hs; vsc = obs_vs;
      for (int i = 0; i < 3000; i++) begin
         cycle();
         if (obs_fs) break;
         clks++; rds += obs_rd; hsc += obs_hs; vsc += obs_vs;
      end
   endtask

   initial begin
      int n, clks, rds, hsc, vsc;
      vec_t base;
      fif.fifo_threshold = 1'b1;
      drive_fifo();

      //       p  h hs hss hse v vs vss vse  clks rds hs vs
      tbl[0] = '{0, 8, 4, 5, 7, 4, 2, 3, 4,   32,  8,  8,  8};
      tbl[1] = '{3, 8, 4, 5, 7, 4, 2, 3, 4,  128,  8, 32, 32};
      tbl[2] = '{1, 5, 5, 2, 2, 3, 1, 0, 3,   30,  5,  0, 30};
      tbl[3] = '{0, 0, 1, 0, 1, 2, 2, 1, 0,    2,  2,  2,  0};
      base = tbl[0];

      do_reset();
      check("reset_outputs", int'({hsync, hblank, vsync, vblank, R, G, B, frame_start, underflow, fif.fifo_rd}), 0);

      // frame-level metrics per configuration
      refill = 1;
      for (int t = 0; t < 4; t++) begin
         set_cfg(tbl[t]);
         do_reset();
         en = 1;
         wait_fs("tbl_first_fs", n);
         measure(clks, rds, hsc, vsc);
         check($sformatf("tbl%0d_frame_clks", t), clks, tbl[t].clks);
         check($sformatf("tbl%0d_fifo_rd", t), rds, tbl[t].rds);
         check($sformatf("tbl%0d_hsync_clks", t), hsc, tbl[t].hs_cyc);
         check($sformatf("tbl%0d_vsync_clks", t), vsc, tbl[t].vs_cyc);
      end

      // underflow after five FIFO entries
      refill = 0;
      set_cfg(base);
      do_reset();
      q.delete();
      q.push_back(24'h112233); q.push_back(24'h445566); q.push_back(24'h778899);
      q.push_back(24'hAABBCC); q.push_back(24'hDDEEFF);
      en = 1;
      rds = 0;
      repeat (40) begin cycle(); rds += obs_rd; end
      check("underflow_pops", rds, 5);
      check("underflow_sticky", int'(underflow), 1);
      en = 0;
      repeat (2) cycle();
      check("underflow_cleared", int'(underflow), 0);

      // threshold held low after enable
      refill = 1;
      do_reset();
      fif.fifo_threshold = 1'b0;
      en = 1;
      rds = 0; n = 0;
      repeat (20) begin cycle(); rds += obs_rd; n += obs_fs; end
      check("prefill_no_rd", rds, 0);
      check("prefill_no_fs", n, 0);
      fif.fifo_threshold = 1'b1;
      wait_fs("prefill_exit", n);
      check("prefill_to_fs_clks", n, 3);

      // disable mid-line at hcnt=3, then re-enable
      for (int i = 0; i < 200; i++) begin
         cycle();
         if (m_stb && m_h == 2 && m_v == 0) break;
      end
      check("found_hcnt2", int'(m_stb && m_h == 2), 1);
      en = 0;
      cycle();
      check("disable_rd_same_clk", int'(obs_rd), 0);
      cycle();
      check("disable_outputs_zero", int'({hsync, hblank, vsync, vblank, R, G, B, frame_start}), 0);
      en = 1;
      wait_fs("reenable", n);
      check("reenable_to_fs_clks", n, 4);

      // hsize change mid-frame takes effect at the next frame
      measure(clks, rds, hsc, vsc);
      hsize = CW'(6);
      measure(clks, rds, hsc, vsc);
      check("hsize_current_frame_rd", rds, 8);
      measure(clks, rds, hsc, vsc);
      check("hsize_next_frame_rd", rds, 12);

      // randomized configurations, FIFO behaviour and enable drops
      refill = 0;
      rnd_push = 1;
      for (int it = 0; it < 30; it++) begin
         vec_t c;
         c.p = $urandom_range(0, 3); c.h = $urandom_range(0, 10); c.hs = $urandom_range(0, 11);
         c.hss = $urandom_range(0, 11); c.hse = $urandom_range(0, 11);
         c.v = $urandom_range(0, 5); c.vs = $urandom_range(0, 6);
         c.vss = $urandom_range(0, 6); c.vse = $urandom_range(0, 6);
         set_cfg(c);
         if ($urandom % 3 == 0) do_reset();
         en = 1;
         for (int j = 0; j < 150; j++) begin
            fif.fifo_threshold = ($urandom % 4 != 0);
            if ($urandom % 60 == 0) en = 0; else en = 1;
            if ($urandom % 40 == 0) hsize = CW'($urandom_range(0, 11));
            if ($urandom % 40 == 0) pcnt = PW'($urandom_range(0, 3));
            cycle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/vid_timing_gen.md
Name: vid_timing_gen

Overview:
- Downstream pixel/timing stage of the video controller.
- Consumes the programmed CR/H1/H2/V1/V2 fields and the 24-bit pixel FIFO (R,G,B packed).
- Generates pixel-rate strobes, horizontal/vertical counters, sync/blank outputs and registered RGB to the display.
- Pops one FIFO entry per active pixel; outputs black and flags underflow when data is missing.

Parameters:
- CW, 13, width of timing fields and h/v counters.
- PW, 6, width of pixel divider field pcnt.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset; sampled on posedge clk.
- en  in  1  controller enable (CR bit 3).
- pcnt  in  PW  pixel divider; pixel strobe every pcnt+1 clocks.
- hend  in  CW  total pixels per line.
- hsize  in  CW  displayed pixels per line.
- hsync_start  in  CW  first pixel of hsync.
- hsync_end  in  CW  first pixel after hsync.
- vend  in  CW  total lines per frame.
- vsize  in  CW  displayed lines per frame.
- vsync_start  in  CW  first line of vsync.
- vsync_end  in  CW  first line after vsync.
- fifo_rdata  in  24  FIFO head data {R,G,B}, combinational read.
- fifo_empty  in  1  FIFO empty.
- fifo_threshold  in  1  FIFO at or above half full.
- fifo_rd  out  1  pop request, one clk per popped pixel.
- hsync, hblank, vsync, vblank  out  1  active-high timing outputs.
- R, G, B  out  8 each  pixel colour.
- frame_start  out  1  one-clk pulse at pixel (0,0).
- underflow  out  1  sticky: active pixel found FIFO empty.

Behaviour:
- Reset (reset_n=0 at posedge):
  - State=IDLE; counters, divider and shadow registers cleared.
  - All outputs 0.
- States: IDLE, PREFILL, RUN.
- IDLE:
  - fifo_rd=0; outputs held 0.
  - en=1 moves to PREFILL and latches all timing fields plus pcnt into shadow registers.
- PREFILL:
  - Wait for fifo_threshold=1, then go to RUN with hcnt=vcnt=0 and divider=0.
  - en=0 returns to IDLE.
- RUN, pixel divider:
  - div counts 0..pcnt_s.
  - strobe = (div==pcnt_s); pcnt_s=0 gives a strobe every clk.
- RUN, counters (advance on strobe only):
  - hcnt counts 0..hend_s-1, then wraps to 0 and vcnt increments.
  - vcnt counts 0..vend_s-1, then wraps to 0.
  - On frame wrap, shadow registers reload from inputs; there are no mid-frame config changes.
  - hend_s or vend_s of 0 is treated as 1.
- Timing decode, for the counter value (hcnt,vcnt) at a strobe; registered, visible the clk after the strobe, held between strobes:
  - hblank = hcnt>=hsize_s.
  - hsync = hsync_start_s<=hcnt<hsync_end_s.
  - vblank = vcnt>=vsize_s.
  - vsync = vsync_start_s<=vcnt<vsync_end_s.
  - An empty range (start>=end) gives a sync that never asserts.
- active = strobe & ~(hcnt>=hsize_s) & ~(vcnt>=vsize_s).
- fifo_rd = active & ~fifo_empty. This is combinational, the same clk as the strobe, and never asserted outside RUN.
- RGB, registered on the same edge as the timing outputs:
  - active & ~fifo_empty: {R,G,B} <= fifo_rdata.
  - active & fifo_empty: RGB <= 0 and underflow <= 1.
  - Non-active strobe: RGB <= 0.
- underflow clears only on reset or return to IDLE.
- frame_start pulses 1 clk, aligned with the timing outputs of pixel (0,0).
- en=0 in RUN: next clk goes to IDLE, all outputs 0, fifo_rd deasserted that same clk.
- A reset_n low mid-line behaves identically to power-on reset.
- Latency: strobe to outputs is 1 clk. Entry to RUN to the first strobe is pcnt_s+1 clks.

Optional Feature:
- Macro VID_TESTPAT_EN.
- Defined:
  - Input testpat (1 bit) is added.
  - When testpat=1 in RUN, RGB comes from an 8-bar colour pattern: bar index = hcnt[CW-1:0]*8/hsize_s, bit2→R=FF, bit1→G=FF, bit0→B=FF.
  - fifo_rd is held 0 and underflow is not set.
  - PREFILL is skipped (IDLE→RUN directly).
- Undefined: no testpat port; FIFO is the only pixel source.

Test Plan:
- Reset then en=1, pcnt=0, hend=8, hsize=4, hsync 5..7, vend=4, vsize=2, vsync 3..4, FIFO prefilled with 16 entries and threshold=1:
  - hblank pattern per line is 0000 1111.
  - hsync is high for pixels 5,6.
  - vblank is high on lines 2,3; vsync is high on line 3.
  - fifo_rd fires 8 times per frame.
- pcnt=3, same config: strobes every 4 clks; each pixel's outputs are held 4 clks; frame length 128 clks.
- Feed RGB 0x112233, 0x445566… with the FIFO going empty after 5 entries:
  - First 5 active pixels output the data.
  - 6th outputs 000000; underflow=1 and stays set until en toggles low.
- Hold fifo_threshold=0 for 20 clks after en: no strobes, fifo_rd=0, outputs 0; RUN is entered the clk after threshold rises.
- Deassert en mid-line at hcnt=3: next clk all outputs 0, fifo_rd=0. Re-enable gives frame_start at (0,0) after PREFILL.
- Change hsize from 4 to 6 mid-frame: the current frame keeps 4 active pixels; the next frame shows 6.
